// File: rtl/reg_rename_pkg.sv
// Shared types and sizes for the register rename controller.
// The operand result struct is what each source lookup reports one cycle after dispatch.
package reg_rename_pkg;

  localparam int TAG_W     = 3;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } operand_res_t;

endpackage

// File: rtl/reg_rename_lookup.sv
// Per-source rename lookup: resolves busy/tag from the pre-update tables and
// detects a same-cycle commit that can be bypassed straight into the result.
module rename_lookup
  import reg_rename_pkg::*;
#(
  parameter int TAG_W = reg_rename_pkg::TAG_W
) (
  input  logic [REG_IDX_W-1:0]       rs,
  input  logic [NREG-1:0]            busy_tbl,
  input  logic [NREG-1:0][TAG_W-1:0] tag_tbl,
  input  logic                       cmt_fire,
  input  logic [REG_IDX_W-1:0]       cmt_rd,
  input  logic [TAG_W-1:0]           cmt_tag,
  input  logic [DATA_W-1:0]          cmt_data,
  output logic                       res_busy,
  output logic [TAG_W-1:0]           res_tag,
  output logic [DATA_W-1:0]          res_val,
  output logic                       use_rf
);

  always_comb begin
    res_busy = 1'b0;
    res_tag  = '0;
    res_val  = '0;
    use_rf   = 1'b0;
    if (rs != '0) begin
      // A matching commit this cycle supplies the value the RF cannot yet return.
      if (cmt_fire && (cmt_rd == rs) && (tag_tbl[rs] == cmt_tag)) begin
        res_val = cmt_data;
      end else if (busy_tbl[rs]) begin
        res_busy = 1'b1;
        res_tag  = tag_tbl[rs];
      end else begin
        use_rf = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_rename_ctrl.sv
// Register rename controller: tracks busy/producer-tag per architectural register,
// issues RF reads/writes and reports each source operand one cycle after dispatch.
module reg_rename_ctrl
  import reg_rename_pkg::*;
#(
  parameter int TAG_W = reg_rename_pkg::TAG_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 disp_valid,
  input  logic [4:0]           disp_rs1,
  input  logic [4:0]           disp_rs2,
  input  logic [4:0]           disp_rd,
  input  logic                 disp_rd_en,
  input  logic [TAG_W-1:0]     disp_tag,
  input  logic                 cmt_valid,
  input  logic [4:0]           cmt_rd,
  input  logic [TAG_W-1:0]     cmt_tag,
  input  logic [31:0]          cmt_data,
  input  logic                 flush,
  output logic                 rf_rd_en,
  output logic [4:0]           rf_rs1,
  output logic [4:0]           rf_rs2,
  input  logic [31:0]          rf_rs1_data,
  input  logic [31:0]          rf_rs2_data,
  output logic                 rf_wr_en,
  output logic [4:0]           rf_wr_rd,
  output logic [31:0]          rf_wr_data,
  output logic                 out_valid,
  output logic                 out_rs1_busy,
  output logic [TAG_W-1:0]     out_rs1_tag,
  output logic [31:0]          out_rs1_val,
  output logic                 out_rs2_busy,
  output logic [TAG_W-1:0]     out_rs2_tag,
  output logic [31:0]          out_rs2_val
);

  logic                       disp_fire;
  logic                       cmt_fire;
  logic [NREG-1:0]            busy_q;
  logic [NREG-1:0][TAG_W-1:0] tag_q;

  logic                       lk1_busy, lk2_busy;
  logic [TAG_W-1:0]           lk1_tag, lk2_tag;
  logic [DATA_W-1:0]          lk1_val, lk2_val;
  logic                       lk1_use_rf, lk2_use_rf;

  logic                       out_valid_q;
  operand_res_t               res1_q, res2_q;
  logic                       use_rf1_q, use_rf2_q;

  assign disp_fire  = disp_valid & rdy_in & ~flush;
  assign cmt_fire   = cmt_valid & rdy_in;

  assign rf_rd_en   = disp_fire;
  assign rf_rs1     = disp_rs1;
  assign rf_rs2     = disp_rs2;
  assign rf_wr_en   = cmt_fire & (cmt_rd != '0);
  assign rf_wr_rd   = cmt_rd;
  assign rf_wr_data = cmt_data;

  rename_lookup #(.TAG_W(TAG_W)) u_lookup_rs1 (
    .rs       (disp_rs1),
    .busy_tbl (busy_q),
    .tag_tbl  (tag_q),
    .cmt_fire (cmt_fire),
    .cmt_rd   (cmt_rd),
    .cmt_tag  (cmt_tag),
    .cmt_data (cmt_data),
    .res_busy (lk1_busy),
    .res_tag  (lk1_tag),
    .res_val  (lk1_val),
    .use_rf   (lk1_use_rf)
  );

  rename_lookup #(.TAG_W(TAG_W)) u_lookup_rs2 (
    .rs       (disp_rs2),
    .busy_tbl (busy_q),
    .tag_tbl  (tag_q),
    .cmt_fire (cmt_fire),
    .cmt_rd   (cmt_rd),
    .cmt_tag  (cmt_tag),
    .cmt_data (cmt_data),
    .res_busy (lk2_busy),
    .res_tag  (lk2_tag),
    .res_val  (lk2_val),
    .use_rf   (lk2_use_rf)
  );

  // Dispatch is written after commit so it wins when both target the same rd.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      tag_q  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        busy_q <= '0;
      end else begin
        if (cmt_fire && (cmt_rd != '0) && (tag_q[cmt_rd] == cmt_tag)) begin
          busy_q[cmt_rd] <= 1'b0;
        end
        if (disp_valid && disp_rd_en && (disp_rd != '0)) begin
          busy_q[disp_rd] <= 1'b1;
          tag_q[disp_rd]  <= disp_tag;
        end
      end
    end
  end

  // While stalled, RF-sourced values are captured so the outputs stay frozen.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_valid_q <= 1'b0;
      res1_q      <= '0;
      res2_q      <= '0;
      use_rf1_q   <= 1'b0;
      use_rf2_q   <= 1'b0;
    end else if (rdy_in) begin
      out_valid_q <= disp_fire;
      if (disp_fire) begin
        res1_q    <= {lk1_busy, lk1_tag, lk1_val};
        res2_q    <= {lk2_busy, lk2_tag, lk2_val};
        use_rf1_q <= lk1_use_rf;
        use_rf2_q <= lk2_use_rf;
      end
    end else begin
      if (use_rf1_q) begin
        res1_q.val <= rf_rs1_data;
        use_rf1_q  <= 1'b0;
      end
      if (use_rf2_q) begin
        res2_q.val <= rf_rs2_data;
        use_rf2_q  <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_busy = res1_q.busy;
  assign out_rs1_tag  = res1_q.tag;
  assign out_rs1_val  = use_rf1_q ? rf_rs1_data : res1_q.val;
  assign out_rs2_busy = res2_q.busy;
  assign out_rs2_tag  = res2_q.tag;
  assign out_rs2_val  = use_rf2_q ? rf_rs2_data : res2_q.val;

endmodule

// File: doc/reg_rename_ctrl.md
REG_RENAME_CTRL -- requirements
Module: reg_rename_ctrl

Interface
REQ-001 Parameter TAG_W, default 3, ROB tag width (8 ROB entries).
REQ-002 clk_in  input  1  sole clock, rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  global enable; low = all state and registered outputs hold.
REQ-005 disp_valid  input  1  dispatch request this cycle.
REQ-006 disp_rs1, disp_rs2, disp_rd  input  5 each  source and destination register indices.
REQ-007 disp_rd_en  input  1  instruction writes disp_rd.
REQ-008 disp_tag  input  TAG_W  ROB tag of the dispatching instruction.
REQ-009 cmt_valid  input  1  ROB commit this cycle.
REQ-010 cmt_rd  input  5, cmt_tag  input  TAG_W, cmt_data  input  32  commit destination, tag, value.
REQ-011 flush  input  1  mispredict flush.
REQ-012 rf_rd_en  output  1, rf_rs1/rf_rs2  output  5  register-file read request.
REQ-013 rf_rs1_data/rf_rs2_data  input  32  register-file read data, valid one cycle after rf_rd_en.
REQ-014 rf_wr_en  output  1, rf_wr_rd  output  5, rf_wr_data  output  32  register-file write port.
REQ-015 out_valid  output  1  operand result valid.
REQ-016 out_rsN_busy  output  1, out_rsN_tag  output  TAG_W, out_rsN_val  output  32  per source N=1,2.

Function
REQ-017 State: per-register busy bit and TAG_W-bit producer tag, 32 entries; x0 never busy.
REQ-018 rf_rd_en = disp_valid & rdy_in & ~flush; rf_rs1/rf_rs2 = disp_rs1/disp_rs2 (combinational).
REQ-019 rf_wr_en = cmt_valid & rdy_in & (cmt_rd != 0); rf_wr_rd/rf_wr_data = cmt_rd/cmt_data (combinational).
REQ-020 Commit clears busy[cmt_rd] only when tag[cmt_rd] == cmt_tag; mismatched tag leaves entry unchanged.
REQ-021 Dispatch with disp_rd_en and disp_rd != 0 sets busy[disp_rd]=1, tag[disp_rd]=disp_tag.
REQ-022 Lookup uses pre-update state: rs1 == rd in the same instruction reports the older producer.
REQ-023 Latency 1: out_valid asserted in the cycle after an accepted dispatch, low otherwise.
REQ-024 out_rsN_busy/tag registered from lookup; out_rsN_val = rf_rsN_data unless forwarded (REQ-025); val is don't-care when busy, driven 0.
REQ-025 Commit-to-dispatch bypass: same-cycle commit with cmt_rd == rsN, rsN != 0, tag match -> report busy=0 and register cmt_data as out_rsN_val.
REQ-026 Same-cycle dispatch and commit to the same rd: dispatch wins, entry becomes busy with disp_tag.
REQ-027 flush clears all busy bits at the edge and drops any same-cycle dispatch (out_valid=0 next cycle); same-cycle commit write still reaches the register file.
REQ-028 Source index 0 always reports busy=0, val=0.
REQ-029 rdy_in low: no state update, rf_rd_en/rf_wr_en low, out_* hold.

Reset
REQ-030 On rst_in low: all busy=0, all tags=0, out_valid=0, out_rsN_busy=0, out_rsN_tag=0, out_rsN_val=0, forwarding registers 0.
REQ-031 Reset mid-operation discards any pending result; first dispatch after release behaves as from empty state.

Structure
REQ-032 Shared package holds TAG_W, NREG=32, REG_IDX_W=5, and the operand-result struct (busy, tag, val).
REQ-033 One sub-module, rename_lookup: combinational per-source busy/tag/bypass resolution, instantiated twice.

Verification
REQ-034 After reset, dispatch rs1=5, rs2=6 with rf data 0x11/0x22 -> next cycle out_valid=1, busy=0, vals 0x11/0x22.
REQ-035 Dispatch rd=5 tag=3, then dispatch rs1=5 -> out_rs1_busy=1, out_rs1_tag=3.
REQ-036 busy[5] tag=3; same cycle commit rd=5 tag=3 data=0xAB and dispatch rs1=5 -> busy=0, out_rs1_val=0xAB.
REQ-037 busy[5] tag=4 (re-renamed); commit rd=5 tag=3 -> busy[5] stays 1, tag 4; rf_wr_en=1 with data written.
REQ-038 Registers 1..4 busy; flush with simultaneous dispatch -> out_valid=0 next cycle, later lookups all busy=0.
REQ-039 Dispatch rd=0 tag=2, then rs1=0 -> busy=0, val=0; assert rst_in low during pending result -> out_valid=0.
